// File: rtl/fetch_aligner_pkg.sv
// Shared definitions for the instruction-fetch aligner: FSM states,
// full-length opcode marker and default reset PC.
package fetch_defs;

    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_DEC   = 3'd1,
        S_SPLIT = 3'd2,
        S_JOIN  = 3'd3,
        S_DRAIN = 3'd4
    } fetch_state_t;

    localparam logic [1:0]  OP_FULL          = 2'b11;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_aligner_decompressor.sv
// RV32C -> RV32I expander (combinational). Only the low halfword is
// decoded; unrecognised encodings expand to 32'h0 (an illegal instruction).
module Decompressor (
    input  logic [31:0] inst_in,
    output logic [31:0] inst_out
);

    logic [15:0] c;
    logic [4:0]  rd, rs2, rdp, rs1p;
    logic        unused_hi;

    assign c         = inst_in[15:0];
    assign unused_hi = ^inst_in[31:16];
    assign rd        = c[11:7];
    assign rs2       = c[6:2];
    assign rdp       = {2'b01, c[4:2]};
    assign rs1p      = {2'b01, c[9:7]};

    always_comb begin
        inst_out = 32'h0;
        case ({c[15:13], c[1:0]})
            5'b000_00: if (c[12:5] != 8'h0)
                inst_out = {2'b0, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rdp, 7'h13};
            5'b010_00: inst_out = {5'b0, c[5], c[12:10], c[6], 2'b00, rs1p, 3'b010, rdp, 7'h03};
            5'b110_00: inst_out = {5'b0, c[5], c[12], rdp, rs1p, 3'b010, c[11:10], c[6], 2'b00, 7'h23};
            5'b000_01: inst_out = {{7{c[12]}}, c[6:2], rd, 3'b000, rd, 7'h13};
            // c.jal links to x1, c.j to x0; funct3 bit 2 tells them apart
            5'b001_01, 5'b101_01:
                inst_out = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], c[12],
                            {8{c[12]}}, 4'b0, ~c[15], 7'h6f};
            5'b010_01: inst_out = {{7{c[12]}}, c[6:2], 5'd0, 3'b000, rd, 7'h13};
            5'b011_01: begin
                if (rd == 5'd2)
                    inst_out = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0, 5'd2, 3'b000, 5'd2, 7'h13};
                else
                    inst_out = {{15{c[12]}}, c[6:2], rd, 7'h37};
            end
            5'b100_01: begin
                case (c[11:10])
                    2'b00: inst_out = {7'b0000000, c[6:2], rs1p, 3'b101, rs1p, 7'h13};
                    2'b01: inst_out = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, 7'h13};
                    2'b10: inst_out = {{7{c[12]}}, c[6:2], rs1p, 3'b111, rs1p, 7'h13};
                    default: begin
                        case (c[6:5])
                            2'b00:   inst_out = {7'b0100000, rdp, rs1p, 3'b000, rs1p, 7'h33};
                            2'b01:   inst_out = {7'b0000000, rdp, rs1p, 3'b100, rs1p, 7'h33};
                            2'b10:   inst_out = {7'b0000000, rdp, rs1p, 3'b110, rs1p, 7'h33};
                            default: inst_out = {7'b0000000, rdp, rs1p, 3'b111, rs1p, 7'h33};
                        endcase
                    end
                endcase
            end
            5'b110_01, 5'b111_01:
                inst_out = {c[12], {3{c[12]}}, c[6:5], c[2], 5'd0, rs1p, 2'b00, c[13],
                            c[11:10], c[4:3], c[12], 7'h63};
            5'b000_10: inst_out = {7'b0, c[6:2], rd, 3'b001, rd, 7'h13};
            5'b010_10: inst_out = {4'b0, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, rd, 7'h03};
            5'b100_10: begin
                if (!c[12])
                    inst_out = (rs2 == 5'd0) ? {12'b0, rd, 3'b000, 5'd0, 7'h67}
                                             : {7'b0, rs2, 5'd0, 3'b000, rd, 7'h33};
                else if (rs2 == 5'd0 && rd == 5'd0)
                    inst_out = 32'h0010_0073;
                else if (rs2 == 5'd0)
                    inst_out = {12'b0, rd, 3'b000, 5'd1, 7'h67};
                else
                    inst_out = {7'b0, rs2, rd, 3'b000, rd, 7'h33};
            end
            5'b110_10: inst_out = {4'b0, c[8:7], c[12], rs2, 5'd2, 3'b010, c[11:9], 2'b00, 7'h23};
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_aligner.sv
// Instruction-fetch aligner: word fetch, halfword extraction, split joins.
// Compressed support is built only when FETCH_RVC_EN is defined.
module fetch_aligner
    import fetch_defs::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        inst_is_c,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

`ifdef FETCH_RVC_EN
    localparam logic [31:0] PC_MASK = ~32'h1;
`else
    localparam logic [31:0] PC_MASK = ~32'h3;
`endif

    fetch_state_t state, state_nx;
    logic [31:0]  pc, pc_nx, wbuf, wbuf_nx, ld_inst;
    logic [29:0]  drain_addr, drain_addr_nx;
    logic         ld, ld_c, slot_free, req_open;

    assign slot_free = !inst_valid || inst_ready;
    assign req_open  = (state == S_REQ || state == S_SPLIT || state == S_DRAIN) && !imem_valid;

`ifdef FETCH_RVC_EN
    logic [15:0] hold, hold_nx, half;
    logic [31:0] dec_inst;
    logic        is_c;

    assign half = pc[1] ? wbuf[31:16] : wbuf[15:0];
    assign is_c = half[1:0] != OP_FULL;

    Decompressor u_dec (
        .inst_in  ({16'h0, half}),
        .inst_out (dec_inst)
    );
`endif

    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc[31:2];
        case (state)
            S_REQ:   imem_req = 1'b1;
            S_SPLIT: begin imem_req = 1'b1; imem_addr = pc[31:2] + 30'd1; end
            S_DRAIN: begin imem_req = 1'b1; imem_addr = drain_addr; end
            default: ;
        endcase
        if (rst) imem_req = 1'b0;
    end

    always_comb begin
        state_nx      = state;
        pc_nx         = pc;
        wbuf_nx       = wbuf;
        drain_addr_nx = drain_addr;
        ld            = 1'b0;
        ld_inst       = wbuf;
        ld_c          = 1'b0;
`ifdef FETCH_RVC_EN
        hold_nx       = hold;
`endif
        case (state)
            S_REQ: if (imem_valid) begin wbuf_nx = imem_rdata; state_nx = S_DEC; end
            S_DEC: if (slot_free) begin
`ifdef FETCH_RVC_EN
                if (is_c) begin
                    ld = 1'b1; ld_inst = dec_inst; ld_c = 1'b1;
                    pc_nx = pc + 32'd2;
                    state_nx = pc[1] ? S_REQ : S_DEC;
                end else if (!pc[1]) begin
                    ld = 1'b1; pc_nx = pc + 32'd4; state_nx = S_REQ;
                end else begin
                    hold_nx = half; state_nx = S_SPLIT;
                end
`else
                ld = 1'b1; pc_nx = pc + 32'd4; state_nx = S_REQ;
`endif
            end
`ifdef FETCH_RVC_EN
            S_SPLIT: if (imem_valid) begin wbuf_nx = imem_rdata; state_nx = S_JOIN; end
            // pc stays odd-halfword, so S_DEC continues with the upper half of the new word
            S_JOIN: if (slot_free) begin
                ld = 1'b1; ld_inst = {wbuf[15:0], hold};
                pc_nx = pc + 32'd4; state_nx = S_DEC;
            end
`endif
            S_DRAIN: if (imem_valid) state_nx = S_REQ;
            default: state_nx = S_REQ;
        endcase
        // an open request must still complete on the bus, so drain it at its old address
        if (redirect) begin
            ld    = 1'b0;
            pc_nx = redirect_pc & PC_MASK;
            if (req_open) begin
                state_nx      = S_DRAIN;
                drain_addr_nx = imem_addr;
            end else begin
                state_nx = S_REQ;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_REQ;
            pc         <= RESET_PC & PC_MASK;
            wbuf       <= 32'h0;
            drain_addr <= 30'h0;
            inst_valid <= 1'b0;
            inst_out   <= 32'h0;
            inst_pc    <= 32'h0;
        end else begin
            state      <= state_nx;
            pc         <= pc_nx;
            wbuf       <= wbuf_nx;
            drain_addr <= drain_addr_nx;
            if (redirect) begin
                inst_valid <= 1'b0;
            end else if (ld) begin
                inst_valid <= 1'b1;
                inst_out   <= ld_inst;
                inst_pc    <= pc;
            end else if (inst_ready) begin
                inst_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_RVC_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold      <= 16'h0;
            inst_is_c <= 1'b0;
        end else begin
            hold <= hold_nx;
            if (ld && !redirect) inst_is_c <= ld_c;
        end
    end
`else
    assign inst_is_c = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_aligner.sv
// Scoreboard bench for fetch_aligner; expectations follow FETCH_RVC_EN.
module tb_fetch_aligner;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_valid, inst_valid, inst_ready, inst_is_c, redirect;
    logic [29:0] imem_addr;
    logic [31:0] imem_rdata, inst_out, inst_pc, redirect_pc;

    logic [31:0] mem [0:63];
    logic        mem_stall = 1'b0;
    logic [29:0] rd_log [$];
    exp_t        exp_q [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    fetch_aligner #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_out(inst_out), .inst_pc(inst_pc), .inst_is_c(inst_is_c),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    // one-cycle memory: answers a request the cycle after it is seen
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_valid <= 1'b0;
            imem_rdata <= 32'h0;
            rd_log.delete();
        end else if (imem_req && !imem_valid && !mem_stall) begin
            imem_valid <= 1'b1;
            imem_rdata <= mem[imem_addr[5:0]];
            rd_log.push_back(imem_addr);
        end else begin
            imem_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst && inst_valid && inst_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out got inst=%h pc=%h c=%b", inst_out, inst_pc, inst_is_c);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (inst_out !== e.inst || inst_pc !== e.pc || inst_is_c !== e.c) begin
                    errors++;
                    $display("FAIL out got inst=%h pc=%h c=%b want inst=%h pc=%h c=%b",
                             inst_out, inst_pc, inst_is_c, e.inst, e.pc, e.c);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    endtask

    task automatic do_reset(input bit check);
        rst = 1'b1; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        tick(); tick();
        if (check) begin
            @(negedge clk);
            chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
            chk("rst_imem_addr", {2'b0, imem_addr}, 32'h0);
            chk("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
            chk("rst_inst_out", inst_out, 32'h0);
            chk("rst_inst_pc", inst_pc, 32'h0);
            chk("rst_inst_is_c", {31'h0, inst_is_c}, 32'h0);
            tick();
        end
        rst = 1'b0;
    endtask

    task automatic expect_out(input logic [31:0] i, input logic [31:0] p, input logic c);
        exp_t e;
        e.inst = i; e.pc = p; e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_empty(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
        tick();
        inst_ready = 1'b0;
    endtask

    initial begin
        int n, cnt, snap;
        inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        clear_mem();

        // aligned 32-bit word at reset PC
        mem[0] = 32'h0000_0013; mem[1] = 32'h0000_0013;
        do_reset(1'b1);
        expect_out(32'h0000_0013, 32'h0, 1'b0);
        inst_ready = 1'b1;
        wait_empty(30);
        repeat (6) tick();
        chk("t1_reads", rd_log.size() >= 2 ? 32'd1 : 32'd0, 32'd1);
        if (rd_log.size() >= 2) begin
            chk("t1_addr0", {2'b0, rd_log[0]}, 32'd0);
            chk("t1_addr1", {2'b0, rd_log[1]}, 32'd1);
        end

        // two compressed instructions in one word
        clear_mem();
        mem[0] = 32'h4581_4501; mem[1] = 32'h0000_0013;
        do_reset(1'b0);
`ifdef FETCH_RVC_EN
        expect_out(32'h0000_0513, 32'h0, 1'b1);
        expect_out(32'h0000_0593, 32'h2, 1'b1);
`else
        expect_out(32'h4581_4501, 32'h0, 1'b0);
`endif
        inst_ready = 1'b1;
        wait_empty(30);
        cnt = 0;
        foreach (rd_log[i]) if (rd_log[i] == 30'd0) cnt++;
        chk("t2_word0_reads", cnt, 32'd1);

        // 32-bit instruction split across a word boundary
        clear_mem();
        mem[0] = 32'h0513_0001; mem[1] = 32'h4501_0000;
        do_reset(1'b0);
`ifdef FETCH_RVC_EN
        expect_out(32'h0000_0013, 32'h0, 1'b1);
        expect_out(32'h0000_0513, 32'h2, 1'b0);
        expect_out(32'h0000_0513, 32'h6, 1'b1);
`else
        expect_out(32'h0513_0001, 32'h0, 1'b0);
        expect_out(32'h4501_0000, 32'h4, 1'b0);
`endif
        inst_ready = 1'b1;
        wait_empty(40);

        // back-pressure: outputs frozen, no further reads while stalled
        clear_mem();
        mem[0] = 32'h0000_0013; mem[1] = 32'h0010_0093;
        do_reset(1'b0);
        n = 0;
        while (!inst_valid && n < 20) begin @(negedge clk); n++; end
        chk("t4_valid_seen", {31'h0, inst_valid}, 32'h1);
        snap = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 1) snap = rd_log.size();
            chk("t4_valid", {31'h0, inst_valid}, 32'h1);
            chk("t4_out", inst_out, 32'h0000_0013);
            chk("t4_pc", inst_pc, 32'h0);
            chk("t4_is_c", {31'h0, inst_is_c}, 32'h0);
        end
        chk("t4_reads_frozen", rd_log.size(), snap);
        expect_out(32'h0000_0013, 32'h0, 1'b0);
        expect_out(32'h0010_0093, 32'h4, 1'b0);
        tick();
        inst_ready = 1'b1;
        wait_empty(30);

        // redirect while a request is outstanding
        clear_mem();
        mem[0] = 32'hBAD0_0013; mem[16] = 32'h0050_0293;
        mem_stall = 1'b1;
        do_reset(1'b0);
        inst_ready = 1'b1;
        repeat (3) tick();
        redirect = 1'b1; redirect_pc = 32'h41;
        tick();
        redirect = 1'b0; mem_stall = 1'b0;
        expect_out(32'h0050_0293, 32'h40, 1'b0);
        wait_empty(30);
        chk("t5_reads", rd_log.size() >= 2 ? 32'd1 : 32'd0, 32'd1);
        if (rd_log.size() >= 2) begin
            chk("t5_stale_addr", {2'b0, rd_log[0]}, 32'd0);
            chk("t5_new_addr", {2'b0, rd_log[1]}, 32'd16);
        end

        // PC wraps from the top of the address space to zero
        clear_mem();
        mem[63] = 32'h00a0_0513; mem[0] = 32'h00b0_0593;
        mem_stall = 1'b1;
        do_reset(1'b0);
        inst_ready = 1'b1;
        tick();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0; mem_stall = 1'b0;
        expect_out(32'h00a0_0513, 32'hFFFF_FFFC, 1'b0);
        expect_out(32'h00b0_0593, 32'h0, 1'b0);
        wait_empty(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
